// File: rtl/module_volume_if.sv
// module_volume_if: MIDI CC events in, LPF sample stream in,
// scaled sample stream out.
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

interface module_volume_if;
  logic                      midi_rdy;
  logic [`MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]                midi_ch_sysn;
  logic [6:0]                midi_data0;
  logic [6:0]                midi_data1;
  logic                      sample_in_rdy;
  logic signed [17:0]        sample_in;
  logic                      sample_out_rdy;
  logic signed [17:0]        sample_out;
  logic                      sample_drop;

  modport master (
    output midi_rdy,
    output midi_cmd,
    output midi_ch_sysn,
    output midi_data0,
    output midi_data1,
    output sample_in_rdy,
    output sample_in,
    input  sample_out_rdy,
    input  sample_out,
    input  sample_drop
  );

  modport slave (
    input  midi_rdy,
    input  midi_cmd,
    input  midi_ch_sysn,
    input  midi_data0,
    input  midi_data1,
    input  sample_in_rdy,
    input  sample_in,
    output sample_out_rdy,
    output sample_out,
    output sample_drop
  );
endinterface

// File: rtl/module_volume.sv
// module_volume: ramped MIDI-CC volume with a shift-add multiplier.
// Optional macro VOLUME_BOOST_EN extends the gain range to ~2.0.
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module module_volume #(
  parameter logic [3:0]  MIDI_CH   = 4'h0,
  parameter logic [6:0]  CC_NUM    = 7'd7,
  parameter logic [6:0]  GAIN_INIT = 7'd100,
  parameter logic [17:0] RAMP_STEP = 18'h00100
) (
  input logic            clk,
  input logic            reset,
  module_volume_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_MUL,
    S_SAT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [17:0]        r_gain_tgt;
  logic [17:0]        r_gain_cur;
  logic [17:0]        r_mplier;
  logic signed [35:0] r_acc;
  logic signed [35:0] r_mcand;
  logic [4:0]         r_cnt;
  logic signed [17:0] r_sample_out;
  logic               r_out_rdy;
  logic               r_drop;

  logic               w_cc_hit;
  logic [17:0]        w_cc_gain;
  logic [17:0]        w_gain_step;
  logic signed [35:0] w_rnd;
  logic signed [17:0] w_sat;

  // CC value to Q1.17 gain
  function automatic logic [17:0] f_map(
    input logic [6:0] cc
  );
`ifdef VOLUME_BOOST_EN
    f_map = (cc == 7'd0) ? 18'h0 : {cc, 11'h7FF};
`else
    f_map = (cc == 7'h7F) ? 18'h20000
                          : {1'b0, cc, 10'h0};
`endif
  endfunction

  assign w_cc_hit = bus.midi_rdy
                 && (bus.midi_cmd == `MIDI_CMD_CC)
                 && (bus.midi_ch_sysn == MIDI_CH)
                 && (bus.midi_data0 == CC_NUM);
  assign w_cc_gain = f_map(bus.midi_data1);

  assign bus.sample_out_rdy = r_out_rdy;
  assign bus.sample_out     = r_sample_out;
  assign bus.sample_drop    = r_drop;

  // one bounded step of gain_cur toward gain_tgt
  always_comb begin
    w_gain_step = r_gain_cur;
    if (r_gain_tgt > r_gain_cur) begin
      if ((r_gain_tgt - r_gain_cur) > RAMP_STEP)
        w_gain_step = r_gain_cur + RAMP_STEP;
      else
        w_gain_step = r_gain_tgt;
    end else if (r_gain_tgt < r_gain_cur) begin
      if ((r_gain_cur - r_gain_tgt) > RAMP_STEP)
        w_gain_step = r_gain_cur - RAMP_STEP;
      else
        w_gain_step = r_gain_tgt;
    end
  end

  // round half up back to Q.0, then clamp to 18-bit signed
  always_comb begin
    w_rnd = (r_acc + 36'sd65536) >>> 17;
    w_sat = w_rnd[17:0];
    if (w_rnd > 36'sd131071)
      w_sat = 18'sh1FFFF;
    else if (w_rnd < -36'sd131072)
      w_sat = 18'sh20000;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // next-state: accept only in IDLE, fixed-length pipeline after
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.sample_in_rdy) w_state_nxt = S_RAMP;
      S_RAMP:
        w_state_nxt = S_MUL;
      S_MUL:
        if (r_cnt == 5'd17) w_state_nxt = S_SAT;
      S_SAT:
        w_state_nxt = S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  // gain target follows matching CC events in any state
  always_ff @(posedge clk) begin
    if (!reset)
      r_gain_tgt <= f_map(GAIN_INIT);
    else if (w_cc_hit)
      r_gain_tgt <= w_cc_gain;
  end

  // latch sample, ramp gain, shift-add multiply LSB first
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gain_cur <= f_map(GAIN_INIT);
      r_mplier   <= 18'h0;
      r_acc      <= 36'sh0;
      r_mcand    <= 36'sh0;
      r_cnt      <= 5'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.sample_in_rdy)
            r_mcand <= {{18{bus.sample_in[17]}},
                        bus.sample_in};
        end
        S_RAMP: begin
          r_gain_cur <= w_gain_step;
          r_mplier   <= w_gain_step;
          r_acc      <= 36'sh0;
          r_cnt      <= 5'd0;
        end
        S_MUL: begin
          if (r_mplier[0])
            r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand <<< 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // output strobe during DONE, drop pulse for busy arrivals
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sample_out <= 18'sh0;
      r_out_rdy    <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_out_rdy    <= (r_state == S_SAT);
      r_sample_out <= (r_state == S_SAT) ? w_sat : 18'sh0;
      r_drop       <= bus.sample_in_rdy
                   && (r_state != S_IDLE);
    end
  end

endmodule
